router_port_fifo: RTL

- Per-unit ingress buffer between one processing unit (FFT, FIR or IIR) and the data bus controller.
- The unit writes 32-bit words with put_req. The data bus controller drains them with get_req and reads the full and empty status.
- Three instances are used, one each for fft, fir and iir. Each instance is a synchronous circular FIFO with registered status flags and sticky error flags.

---
 rtl/router_port_fifo.sv | 107 ++++++++++
 1 files changed

// File: rtl/router_port_fifo.sv
// router_port_fifo
//   Ingress buffer between one processing unit (FFT, FIR or IIR) and the data
//   bus controller. This is a synchronous circular FIFO. The status flags are
//   registered, and the error flags are sticky.
//
// Ports
//   clk         system clock; all logic runs on the rising edge
//   reset       synchronous, active-high; discards all stored words
//   data_in     word written by the processing unit
//   put_req     write request; accepted when the FIFO is not full
//   get_req     read request; accepted when the FIFO is not empty
//   data_out    head word, registered; valid the cycle after an accepted get
//   full        count == depth
//   empty       count == 0
//   almost_full count >= AF_LEVEL
//   count       number of stored words
//   overflow    sticky; set by put_req while full
//   underflow   sticky; set by get_req while empty
//   clear_err   clears overflow/underflow (a same-cycle set wins)
module router_port_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  put_req,
  input  logic                  get_req,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err
);

  localparam int unsigned        DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  put_ok;
  logic                  get_ok;

  always_comb begin
    put_ok     = put_req & ~full;
    get_ok     = get_req & ~empty;
    count_next = count;
    if (put_ok && !get_ok)
      count_next = count + CNT_ONE;
    else if (get_ok && !put_ok)
      count_next = count - CNT_ONE;
  end

  // A put and a get never target the same slot in one cycle. That could only
  // happen at count 0 or count DEPTH, and in those states one of the two
  // requests is rejected. So a read-before-write mem access is safe here.
  always_ff @(posedge clk) begin
    if (!reset && put_ok)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      data_out    <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (put_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (get_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
      // Status is derived only from the next count, never from the pointers.
      count       <= count_next;
      full        <= (count_next == DEPTH_CNT);
      empty       <= (count_next == '0);
      almost_full <= (count_next >= AF_CNT);

      if (put_req && full)
        overflow <= 1'b1;
      else if (clear_err)
        overflow <= 1'b0;

      if (get_req && empty)
        underflow <= 1'b1;
      else if (clear_err)
        underflow <= 1'b0;
    end
  end

endmodule
